// File: rtl/hamming_weight_cal_tx_if.sv
// Byte-stream interface of the Hamming-weight frame transmitter.
// The upstream loader and the receiver-side observer use the master view; the block uses the slave view.
interface hamming_weight_cal_tx_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  bit_string;
  logic        busy;
  logic        frame_done;
  logic [10:0] tx_hamming_weight;

  modport master (
    output in_data, in_valid,
    input  in_ready, bit_string, busy, frame_done, tx_hamming_weight
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, bit_string, busy, frame_done, tx_hamming_weight
  );
endinterface

// File: rtl/hamming_weight_cal_tx.sv
// Buffers one payload frame, then streams START_PACKET, the payload and one guard byte.
// It also reports the popcount of the frame that was just sent.
module hamming_weight_cal_tx #(
  parameter int         PAYLOAD_BYTES = 128,
  parameter logic [7:0] START_PACKET  = 8'hFF,
  parameter logic [7:0] IDLE_BYTE     = 8'h00
) (
  input logic                    clk,
  input logic                    rst,
  hamming_weight_cal_tx_if.slave bus
);

  localparam int IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BYTES - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  typedef enum logic [1:0] {LOAD, START, SEND, GUARD} state_t;

  state_t           state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [10:0]      acc;
  logic [7:0]       bit_string_q;
  logic             frame_done_q;
  logic [10:0]      tx_hw_q;
  logic [7:0]       mem [PAYLOAD_BYTES];
  logic             accept;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
    return n;
  endfunction

  assign accept = bus.in_valid && (state == LOAD);

  // NOTE: the payload buffer has no reset; every entry is rewritten before it is read, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_idx] <= bus.in_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  // Each transition also loads the byte that belongs to the state being entered, so bit_string lines up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD;
      wr_idx       <= '0;
      rd_idx       <= '0;
      acc          <= '0;
      bit_string_q <= IDLE_BYTE;
      frame_done_q <= 1'b0;
      tx_hw_q      <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            acc <= acc + {7'd0, popcount8(bus.in_data)};
            if (wr_idx == LAST_IDX) begin
              state        <= START;
              bit_string_q <= START_PACKET;
            end else begin
              wr_idx <= wr_idx + ONE;
            end
          end
        end
        START: begin
          state        <= SEND;
          rd_idx       <= '0;
          bit_string_q <= mem[0];
        end
        SEND: begin
          if (rd_idx == LAST_IDX) begin
            state        <= GUARD;
            bit_string_q <= IDLE_BYTE;
            frame_done_q <= 1'b1;
            tx_hw_q      <= acc;
            acc          <= '0;
            wr_idx       <= '0;
          end else begin
            rd_idx       <= rd_idx + ONE;
            bit_string_q <= mem[rd_idx + ONE];
          end
        end
        default: begin
          state        <= LOAD;
          bit_string_q <= IDLE_BYTE;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready          = (state == LOAD);
  assign bus.busy              = (state != LOAD);
  assign bus.bit_string        = bit_string_q;
  assign bus.frame_done        = frame_done_q;
  assign bus.tx_hamming_weight = tx_hw_q;

endmodule

// File: tb/tb_hamming_weight_cal_tx.sv
// Randomized self-checking bench: every frame's expected wire sequence and popcount are built from the payload array.
// Covers back-to-back frames, gapped loading, data offered while busy, and reset in the middle of SEND.
module tb_hamming_weight_cal_tx;
  localparam int N = 128;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   held_hw = 0;
  logic [7:0] payload [N];

  hamming_weight_cal_tx_if bus ();

  hamming_weight_cal_tx #(
    .PAYLOAD_BYTES(N),
    .START_PACKET (8'hFF),
    .IDLE_BYTE    (8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " bit_string"}, 32'(bus.bit_string), 32'h00);
    check({tag, " in_ready"},   32'(bus.in_ready),   32'd1);
    check({tag, " busy"},       32'(bus.busy),       32'd0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
    check({tag, " tx_hw"},      32'(bus.tx_hamming_weight), held_hw);
  endtask

  // valid_mode: 0 back-to-back, 1 toggling every other cycle, 2 random gaps.
  // abort_at >= 0 asserts reset right after that SEND cycle.
  task automatic run_frame(input int valid_mode, input int abort_at);
    int   k = 0;
    int   cyc = 0;
    int   exp_hw = 0;
    logic v;
    for (int i = 0; i < N; i++) exp_hw += $countones(payload[i]);

    while (k < N) begin
      case (valid_mode)
        1:       v = (cyc % 2 == 0);
        2:       v = ($urandom_range(0, 3) != 0);
        default: v = 1'b1;
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? payload[k] : 8'($urandom);
      step();
      cyc++;
      if (v) k++;
      if (k < N) check_idle("load");
      if (cyc > 20 * N) begin
        $display("FAIL load_timeout: got %0d bytes expected %0d", k, N);
        $fatal(1, "loading did not complete");
      end
    end

    check("start bit_string", 32'(bus.bit_string), 32'hFF);
    check("start in_ready",   32'(bus.in_ready),   32'd0);
    check("start busy",       32'(bus.busy),       32'd1);
    check("start frame_done", 32'(bus.frame_done), 32'd0);

    for (int j = 0; j < N; j++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      step();
      check("send bit_string", 32'(bus.bit_string), 32'(payload[j]));
      check("send in_ready",   32'(bus.in_ready),   32'd0);
      check("send busy",       32'(bus.busy),       32'd1);
      check("send frame_done", 32'(bus.frame_done), 32'd0);
      check("send tx_hw",      32'(bus.tx_hamming_weight), held_hw);
      if (j == abort_at) begin
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        held_hw = 0;
        check_idle("async_reset");
        for (int r = 0; r < 2; r++) begin
          step();
          check_idle("in_reset");
        end
        rst = 1'b0;
        for (int r = 0; r < 4; r++) begin
          step();
          check_idle("after_reset");
        end
        return;
      end
    end

    step();
    check("guard bit_string", 32'(bus.bit_string), 32'h00);
    check("guard frame_done", 32'(bus.frame_done), 32'd1);
    check("guard busy",       32'(bus.busy),       32'd1);
    check("guard in_ready",   32'(bus.in_ready),   32'd0);
    check("guard tx_hw",      32'(bus.tx_hamming_weight), exp_hw);
    held_hw = exp_hw;

    // Junk still offered on the GUARD edge must be ignored.
    step();
    check_idle("post_guard");
    bus.in_valid = 1'b0;
  endtask

  task automatic fill(input int data_mode);
    for (int i = 0; i < N; i++) begin
      case (data_mode)
        0:       payload[i] = 8'hFF;
        1:       payload[i] = 8'(i);
        2:       payload[i] = 8'h00;
        default: payload[i] = 8'($urandom);
      endcase
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    check_idle("reset_no_clock");
    step();
    step();
    check_idle("reset_clocked");
    rst = 1'b0;
    step();
    check_idle("idle");

    fill(0); run_frame(0, -1);
    fill(1); run_frame(1, -1);
    fill(2); run_frame(0, -1);
    fill(3); run_frame(2, -1);
    fill(3); run_frame(0, 50);
    fill(3); run_frame(2, -1);
    fill(3); run_frame(0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hamming_weight_cal_tx.md
HAMMING_WEIGHT_CAL_TX -- requirements
Module: hamming_weight_cal_tx

Interface
REQ-001 The block SHALL have parameter PAYLOAD_BYTES, default 128, number of payload bytes per frame (1024 bits).
REQ-002 The block SHALL have parameter START_PACKET, default 8'hFF, frame start byte.
REQ-003 The block SHALL have parameter IDLE_BYTE, default 8'h00, value driven whenever no frame byte is being sent.
REQ-004 The block SHALL have the following ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-high.
- in_data  input  8  payload byte from upstream.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- bit_string  output  8  registered byte stream to the receiver, one byte per clk.
- busy  output  1  high in START, SEND and GUARD.
- frame_done  output  1  one-cycle pulse in the GUARD cycle.
- tx_hamming_weight  output  11  popcount of the last transmitted frame's 1024 payload bits.

Function
REQ-005 The block SHALL implement the states LOAD, START, SEND and GUARD, held in a state register.
REQ-006 In LOAD, in_ready SHALL be 1; a byte is accepted on any posedge with in_valid=1 and in_ready=1.
REQ-007 Each accepted byte SHALL be written to internal buffer entry wr_idx (0..PAYLOAD_BYTES-1), and wr_idx SHALL then increment.
REQ-008 Each accepted byte's popcount (0..8) SHALL be added to an 11-bit accumulator; the maximum of 1024 SHALL fit without wrap.
REQ-009 Acceptance of byte PAYLOAD_BYTES-1 SHALL move the state to START on the same edge; in_ready SHALL then be 0 until the state returns to LOAD.
REQ-010 While in_valid=0 in LOAD, state, wr_idx and the accumulator SHALL hold; gaps of any length are legal.
REQ-011 START SHALL last exactly one cycle, with bit_string=START_PACKET during it.
REQ-012 SEND SHALL last exactly PAYLOAD_BYTES cycles; in SEND cycle k (k=0..PAYLOAD_BYTES-1), bit_string SHALL equal buffer[k], with no bubbles.
REQ-013 Payload bytes equal to START_PACKET SHALL be sent unmodified.
REQ-014 GUARD SHALL last exactly one cycle, with bit_string=IDLE_BYTE and frame_done=1.
REQ-015 In the GUARD cycle, tx_hamming_weight SHALL be loaded from the accumulator, and wr_idx and the accumulator SHALL clear.
REQ-016 The state SHALL then return to LOAD.
REQ-017 tx_hamming_weight SHALL hold its value until the next GUARD cycle or reset.
REQ-018 In LOAD, bit_string SHALL equal IDLE_BYTE, so a frame is always preceded by at least PAYLOAD_BYTES idle cycles.
REQ-019 The first cycle after START_PACKET SHALL carry payload byte 0, so the receiver's counter positions 1..PAYLOAD_BYTES map to payload bytes 0..PAYLOAD_BYTES-1.
REQ-020 Position PAYLOAD_BYTES+1 SHALL carry IDLE_BYTE (GUARD), contributing zero weight at the receiver.
REQ-021 in_valid and in_data SHALL be ignored outside LOAD; no byte is lost, because in_ready=0 there.
REQ-022 busy SHALL be 1 exactly when the state is START, SEND or GUARD.
REQ-023 All outputs except in_ready and busy SHALL be registered; in_ready and busy SHALL be decoded from the state register only.

Reset
REQ-024 rst=1 SHALL immediately, without waiting for clk, force: state=LOAD, wr_idx=0, accumulator=0, bit_string=IDLE_BYTE, frame_done=0, tx_hamming_weight=0.
REQ-025 in_ready SHALL be 1 and busy 0 while rst=1.
REQ-026 Buffer contents need not reset.
REQ-027 Reset asserted mid-frame (any state) SHALL abort the frame; no further payload bytes or frame_done SHALL appear.
REQ-028 After rst deasserts, the first accepted byte SHALL be stored as buffer[0].

Verification
REQ-029 Load 128 bytes of 8'hFF back-to-back -> 8'hFF for 129 consecutive cycles (START_PACKET plus payload), then 8'h00 with frame_done=1, tx_hamming_weight=1024.
REQ-030 Load bytes 0..127 (byte k = k) with in_valid toggling every other cycle -> bit_string 8'h00 during loading, then FF,00,01,...,7F,00; tx_hamming_weight=448.
REQ-031 Load 128 bytes of 8'h00 -> FF, 128 x 00, GUARD; tx_hamming_weight=0; frame_done is a single one-cycle pulse.
REQ-032 Two frames back-to-back, where frame 2 is offered with in_valid=1 during frame 1's SEND -> in_ready=0 throughout START/SEND/GUARD; frame 2's bytes are accepted only after GUARD; tx_hamming_weight updates exactly at each GUARD.
REQ-033 Assert rst at SEND cycle 50 -> bit_string=8'h00 at once, tx_hamming_weight=0, no frame_done; a subsequent full load produces a correct complete frame.
REQ-034 Loopback into the existing receiver with a random payload -> the receiver's hamming_weight matches tx_hamming_weight and the software popcount.
